mux_41_scanner: RTL and testbench
=================================

MUX_41_SCANNER -- requirements
Module: mux_41_scanner

Interface
REQ-001 The block SHALL have parameter DWELL, default 4, giving the clock cycles spent on each channel before sampling; the legal range is 1..255.
REQ-002 The block SHALL have parameter NCH, fixed at 4, giving the number of mux channels scanned.
REQ-003 Port clk SHALL be an input, 1 bit wide, serving as the single clock with all state on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit wide, acting as an asynchronous, active-low reset.
REQ-005 Port start SHALL be an input, 1 bit wide, requesting one scan; it is sampled only in IDLE.
REQ-006 Port mode_cont SHALL be an input, 1 bit wide; when it is 1 at handshake, the next scan restarts immediately.
REQ-007 Port y SHALL be an input, 1 bit wide, carrying the output of the downstream 4:1 mux (mux_41_case).
REQ-008 Port sel SHALL be an output, 2 bits wide, carrying the registered channel select that drives mux_41_case sel.
REQ-009 Port data_out SHALL be an output, 4 bits wide, holding the scanned word, where bit k is the y value sampled with sel=k.
REQ-010 Port data_valid SHALL be an output, 1 bit wide, indicating that data_out holds a complete word.
REQ-011 Port data_ready SHALL be an input, 1 bit wide, indicating that the consumer accepts data_out.
REQ-012 Port busy SHALL be an output, 1 bit wide, that is 1 whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, SCAN and HOLD, and SHALL drive all outputs from registers.
REQ-014 In IDLE, when start=1 at edge N, the block SHALL set state=SCAN, sel=0 and dwell count=0.
REQ-015 In SCAN, the dwell counter SHALL increment each cycle.
REQ-016 In SCAN, at the edge where count==DWELL-1, the block SHALL capture y into bit sel, reset the count to 0 and set sel=sel+1.
REQ-017 At the sample edge for sel==3, the block SHALL load all 4 bits into data_out, set data_valid=1 and enter HOLD, with sel wrapping to 0.
REQ-018 Latency SHALL be data_valid=1 after edge N+4*DWELL; with DWELL=4 this is edge N+16, and with DWELL=1 it is edge N+4, sampling on every cycle.
REQ-019 In HOLD, data_out and data_valid SHALL stay stable until data_valid&&data_ready at an edge.
REQ-020 On a handshake with mode_cont=0, the block SHALL clear data_valid and enter IDLE.
REQ-021 On a handshake with mode_cont=1, the block SHALL clear data_valid and enter SCAN with sel=0 and count=0 on the same edge.
REQ-022 The block SHALL ignore start outside IDLE, and SHALL ignore data_ready while data_valid=0.
REQ-023 If start=1 and data_ready=1 occur simultaneously in IDLE, only start SHALL take effect.
REQ-024 data_out SHALL never show a partially scanned word, because intermediate bits are held in an internal shadow register.

Reset
REQ-025 When rst_n=0 the block SHALL, asynchronously, set state=IDLE, sel=0, count=0, shadow=0, data_out=0, data_valid=0 and busy=0.
REQ-026 A reset asserted in the middle of a SCAN or HOLD SHALL abandon the scan, and no data_valid SHALL follow the reset release until a new start.
REQ-027 Reset release SHALL take effect on the first clk edge with rst_n=1.

Configuration
REQ-028 With MUX_SCAN_PARITY_EN defined, the block SHALL add a 1-bit output data_par equal to the XOR of the captured word, registered together with data_out, reset to 0 and held with it in HOLD.
REQ-029 With MUX_SCAN_PARITY_EN undefined, port data_par and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 A shared package mux_scan_pkg SHALL hold the state enum typedef (IDLE/SCAN/HOLD) and the constants NCH=4, SEL_W=2 and CNT_W=8.
REQ-031 The dwell counter SHALL be one sub-module, mux_scan_dwell_cnt, with inputs clear and enable and a terminal-count output at count==DWELL-1.

Verification
REQ-032 With DWELL=4, i0..i3=1,0,1,1 and a start pulse at edge 0 driving mux_41_case, the bench SHALL see sel step 0,1,2,3 every 4 cycles, and data_valid=1 with data_out=4'b1101 after edge 16.
REQ-033 With DWELL=1 and i0..i3=0,1,0,0, the bench SHALL see data_out=4'b0010 with data_valid=1 after edge 4.
REQ-034 With data_valid=1 and data_ready=0 for 10 cycles while the i inputs change, the bench SHALL see data_out stay constant; raising data_ready SHALL give data_valid=0 on the next edge and state IDLE.
REQ-035 With mode_cont=1, data_ready tied to 1 and i0..i3 changed between scans, the bench SHALL see back-to-back words every 4*DWELL cycles, each matching the current inputs, with no idle gap.
REQ-036 With rst_n pulsed low at cycle 6 of a scan, the bench SHALL see all outputs 0 immediately (no clock edge needed), and no data_valid without a new start.
REQ-037 With MUX_SCAN_PARITY_EN defined and data_out=4'b1101, the bench SHALL see data_par=1; with data_out=4'b0000 it SHALL see data_par=0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4-channel mux scanner.
// Used by mux_41_scanner and mux_scan_dwell_cnt.
package mux_scan_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } scan_state_e;

  function automatic logic is_last_channel(input logic [SEL_W-1:0] sel);
    return sel == SEL_W'(NCH - 1);
  endfunction

  function automatic logic word_parity(input logic [NCH-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Dwell counter for the mux scanner: counts 0..DWELL-1 while enabled and
// wraps on its own; tc flags the last cycle of a dwell period.
module mux_scan_dwell_cnt
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count;

  assign tc = (count == LAST);

  // clear wins over enable so a new scan always starts a full dwell period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (tc) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_41_scanner.sv
// Steps the select of a downstream 4:1 mux, samples y after DWELL cycles per
// channel and presents the assembled word with a valid/ready handshake.
// Optional feature: define MUX_SCAN_PARITY_EN to add the data_par output.
module mux_41_scanner
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 4,
  parameter int unsigned NCH   = mux_scan_pkg::NCH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode_cont,
  input  logic             y,
  input  logic             data_ready,
  output logic [SEL_W-1:0] sel,
  output logic [NCH-1:0]   data_out,
  output logic             data_valid,
  output logic             busy
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic             data_par
`endif
);

  scan_state_e      state;
  scan_state_e      state_next;
  logic [NCH-1:0]   shadow;
  logic [NCH-1:0]   captured;
  logic             tc;
  logic             handshake;
  logic             sample;
  logic             scan_done;
  logic             scan_begin;
  logic             cnt_clear;
  logic             cnt_enable;

  mux_scan_dwell_cnt #(
    .DWELL (DWELL)
  ) u_dwell_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .tc     (tc)
  );

  always_comb begin
    handshake  = 1'b0;
    sample     = 1'b0;
    scan_done  = 1'b0;
    scan_begin = 1'b0;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          scan_begin = 1'b1;
          state_next = SCAN;
        end
      end
      SCAN: begin
        cnt_enable = 1'b1;
        if (tc) begin
          sample = 1'b1;
          if (is_last_channel(sel)) begin
            scan_done  = 1'b1;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (data_valid && data_ready) begin
          handshake = 1'b1;
          if (mode_cont) begin
            scan_begin = 1'b1;
            state_next = SCAN;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    cnt_clear = scan_begin;
  end

  // The word is assembled off to the side so data_out only ever changes
  // to a complete word.
  always_comb begin
    captured      = shadow;
    captured[sel] = y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= '0;
      shadow     <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      if (scan_begin) begin
        sel    <= '0;
        shadow <= '0;
      end else if (sample) begin
        shadow <= captured;
        sel    <= sel + 1'b1;
      end
      if (scan_done) begin
        data_out   <= captured;
        data_valid <= 1'b1;
      end else if (handshake) begin
        data_valid <= 1'b0;
      end
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_par <= 1'b0;
    end else if (scan_done) begin
      data_par <= word_parity(captured);
    end
  end
`endif

endmodule

// File: tb/tb_mux_41_scanner.sv
// Randomized self-checking bench for mux_41_scanner with DWELL=4 and DWELL=1,
// modelling the downstream 4:1 mux as y = i[sel].
module tb_mux_41_scanner;

  localparam int unsigned D4 = 4;
  localparam int unsigned D1 = 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;

  logic       start4 = 1'b0;
  logic       mode4  = 1'b0;
  logic       ready4 = 1'b0;
  logic [3:0] in4    = 4'b0;
  logic       y4;
  logic [1:0] sel4;
  logic [3:0] dout4;
  logic       dv4;
  logic       busy4;

  logic       start1 = 1'b0;
  logic       mode1  = 1'b0;
  logic       ready1 = 1'b0;
  logic [3:0] in1    = 4'b0;
  logic       y1;
  logic [1:0] sel1;
  logic [3:0] dout1;
  logic       dv1;
  logic       busy1;

`ifdef MUX_SCAN_PARITY_EN
  logic       par4;
  logic       par1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign y4 = in4[sel4];
  assign y1 = in1[sel1];

  mux_41_scanner #(.DWELL(D4)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start4),
    .mode_cont  (mode4),
    .y          (y4),
    .data_ready (ready4),
    .sel        (sel4),
    .data_out   (dout4),
    .data_valid (dv4),
    .busy       (busy4)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .data_par   (par4)
`endif
  );

  mux_41_scanner #(.DWELL(D1)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .mode_cont  (mode1),
    .y          (y1),
    .data_ready (ready1),
    .sel        (sel1),
    .data_out   (dout1),
    .data_valid (dv1),
    .busy       (busy1)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .data_par   (par1)
`endif
  );

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Called on the falling edge right after the scan-start edge. Bit k of the
  // expected word is input k as driven just before edge (k+1)*DWELL.
  task automatic apply_stimulus(input string tag, input bit rnd,
                                input logic [3:0] fixed, input logic [3:0] prev_word,
                                output logic [3:0] exp_word);
    int k;
    exp_word = 4'b0;
    for (int m = 0; m < 4 * D4; m++) begin
      check_output({tag, "_sel"}, 32'(sel4), 32'((m / D4) % 4));
      check_output({tag, "_valid_low"}, 32'(dv4), 32'd0);
      check_output({tag, "_busy"}, 32'(busy4), 32'd1);
      check_output({tag, "_no_partial"}, 32'(dout4), 32'(prev_word));
      in4 = rnd ? 4'($urandom) : fixed;
      if (rnd) begin
        start4 = 1'($urandom);
        ready4 = 1'($urandom);
      end
      if ((m + 1) % D4 == 0) begin
        k = (m + 1) / D4 - 1;
        exp_word[k] = in4[k];
      end
      @(negedge clk);
    end
    start4 = 1'b0;
    ready4 = 1'b0;
    check_output({tag, "_valid"}, 32'(dv4), 32'd1);
    check_output({tag, "_word"}, 32'(dout4), 32'(exp_word));
    check_output({tag, "_sel_wrap"}, 32'(sel4), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
    check_output({tag, "_par"}, 32'(par4), 32'(^exp_word));
`endif
  endtask

  task automatic hold_stall(input int n, input logic [3:0] word);
    for (int c = 0; c < n; c++) begin
      in4    = 4'($urandom);
      start4 = 1'($urandom);
      mode4  = 1'($urandom);
      ready4 = 1'b0;
      @(negedge clk);
      check_output("hold_valid", 32'(dv4), 32'd1);
      check_output("hold_word", 32'(dout4), 32'(word));
      check_output("hold_busy", 32'(busy4), 32'd1);
`ifdef MUX_SCAN_PARITY_EN
      check_output("hold_par", 32'(par4), 32'(^word));
`endif
    end
    start4 = 1'b0;
    mode4  = 1'b0;
  endtask

  task automatic handshake4(input bit cont);
    start4 = 1'b0;
    ready4 = 1'b1;
    mode4  = cont;
    @(negedge clk);
    ready4 = 1'b0;
    mode4  = 1'b0;
    if (!cont) begin
      check_output("hs_valid_clr", 32'(dv4), 32'd0);
      check_output("hs_idle", 32'(busy4), 32'd0);
    end
  endtask

  task automatic start_pulse4();
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
  endtask

  initial begin
    logic [3:0] w;
    logic [3:0] exp1;
    bit         cont;

    #1;
    check_output("rst_sel", 32'(sel4), 32'd0);
    check_output("rst_dout", 32'(dout4), 32'd0);
    check_output("rst_valid", 32'(dv4), 32'd0);
    check_output("rst_busy", 32'(busy4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scan: i0..i3 = 1,0,1,1 gives 4'b1101.
    in4 = 4'b1101;
    start_pulse4();
    apply_stimulus("fixed1101", 1'b0, 4'b1101, 4'b0000, w);
    hold_stall(10, w);
    handshake4(1'b0);

    // start and data_ready together in IDLE: only start counts.
    in4    = 4'b0000;
    start4 = 1'b1;
    ready4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    ready4 = 1'b0;
    apply_stimulus("start_ready", 1'b0, 4'b0000, w, w);
    handshake4(1'b1);
    apply_stimulus("cont_first", 1'b1, 4'b0000, w, w);

    for (int n = 0; n < 10; n++) begin
      cont = 1'($urandom);
      hold_stall(int'($urandom_range(0, 3)), w);
      handshake4(cont);
      if (!cont) begin
        repeat ($urandom_range(0, 2)) begin
          ready4 = 1'($urandom);
          @(negedge clk);
          check_output("idle_gap_valid", 32'(dv4), 32'd0);
          check_output("idle_gap_busy", 32'(busy4), 32'd0);
        end
        ready4 = 1'b0;
        start_pulse4();
      end
      apply_stimulus("random", 1'b1, 4'b0000, w, w);
    end
    handshake4(1'b0);

    // Reset in the middle of a scan after a non-zero word was delivered.
    in4 = 4'b1101;
    start_pulse4();
    apply_stimulus("pre_reset", 1'b0, 4'b1101, w, w);
    handshake4(1'b0);
    start_pulse4();
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("async_rst_sel", 32'(sel4), 32'd0);
    check_output("async_rst_dout", 32'(dout4), 32'd0);
    check_output("async_rst_valid", 32'(dv4), 32'd0);
    check_output("async_rst_busy", 32'(busy4), 32'd0);
`ifdef MUX_SCAN_PARITY_EN
    check_output("async_rst_par", 32'(par4), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4 * D4 + 4; c++) begin
      ready4 = 1'($urandom);
      @(negedge clk);
      check_output("post_rst_valid", 32'(dv4), 32'd0);
      check_output("post_rst_busy", 32'(busy4), 32'd0);
    end
    ready4 = 1'b0;

    // DWELL=1: i0..i3 = 0,1,0,0 gives 4'b0010 after four edges.
    in1    = 4'b0010;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int m = 0; m < 4; m++) begin
      check_output("d1_sel", 32'(sel1), 32'(m));
      check_output("d1_valid_low", 32'(dv1), 32'd0);
      @(negedge clk);
    end
    check_output("d1_valid", 32'(dv1), 32'd1);
    check_output("d1_word", 32'(dout1), 32'h2);
`ifdef MUX_SCAN_PARITY_EN
    check_output("d1_par", 32'(par1), 32'd1);
`endif
    ready1 = 1'b1;
    mode1  = 1'b1;
    @(negedge clk);
    ready1 = 1'b0;
    mode1  = 1'b0;
    exp1   = 4'b0;
    for (int m = 0; m < 4; m++) begin
      check_output("d1_cont_sel", 32'(sel1), 32'(m));
      check_output("d1_cont_valid_low", 32'(dv1), 32'd0);
      in1     = 4'($urandom);
      exp1[m] = in1[m];
      @(negedge clk);
    end
    check_output("d1_cont_valid", 32'(dv1), 32'd1);
    check_output("d1_cont_word", 32'(dout1), 32'(exp1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
